// File: rtl/display_arbiter.sv
// display_arbiter -- shares one 4-digit 7-segment display among NUM_REQ
// value sources with round-robin grants and a minimum show time per grant.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   req_valid      level request per source (bit i = source i)
//   req_value      packed source values, source i at [i*DATA_W +: DATA_W]
//   req_ack        one-cycle pulse: source i's value was latched this cycle
//   to_display_nr  registered (saturated) value to the display driver
//   display_blank  blank request to the display driver
//   owner          index of the current owner (meaningful while busy=1)
//   busy           1 while a grant is active (HOLD or KEEP)
//   saturated      1 while the displayed value is clamped to MAX_VALUE
//   dbg_state      current FSM state (0=IDLE, 1=HOLD, 2=KEEP)
//
// Handshake: a source raises req_valid and keeps it high for as long as it
// wants the display; it is not a one-shot request. req_ack pulses for one
// clock, coincident with the first registered appearance of that source's
// value. Later live updates from the same owner are not acked. A request
// that is not granted stays pending until it is granted or withdrawn.
//
// Optional feature (macro DISPLAY_ARB_BLANK_EN): when defined, IDLE blanks
// the display and zeroes to_display_nr, and display_blank pulses for one clock
// together with every req_ack. When undefined, display_blank is tied to 0 and
// IDLE keeps the last value.
module display_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int DATA_W      = 14,
   parameter int MAX_VALUE   = 9999,
   parameter int HOLD_CYCLES = 50000000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_value,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [DATA_W-1:0]         to_display_nr,
   output logic                      display_blank,
   output logic [1:0]                owner,
   output logic                      busy,
   output logic                      saturated,
   output logic [1:0]                dbg_state
);

   localparam int                CNT_W    = $clog2(HOLD_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [DATA_W-1:0] MAX_V    = DATA_W'(MAX_VALUE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_KEEP = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   // r_owner doubles as the round-robin pointer: it is rewritten on every grant.
   logic [1:0]          r_owner;
   logic [NUM_REQ-1:0]  r_ack;
   logic [DATA_W-1:0]   r_val;
   logic                r_sat;
   logic                r_busy;
`ifdef DISPLAY_ARB_BLANK_EN
   logic                r_blank;
`endif

   logic                w_excl;
   logic                w_win_valid;
   logic [1:0]          w_win_idx;
   logic [DATA_W-1:0]   w_win_val;
   logic [DATA_W-1:0]   w_owner_val;
   logic                w_owner_req;
   logic                w_grant;
   logic                w_update;
   logic                w_to_keep;
   logic                w_to_idle;

   function automatic logic [DATA_W-1:0] f_sat(input logic [DATA_W-1:0] v);
      return (v > MAX_V) ? MAX_V : v;
   endfunction

   always_comb begin
      // While a grant is active the owner may not win against itself.
      w_excl      = (r_state != S_IDLE);
      w_win_valid = 1'b0;
      w_win_idx   = 2'd0;
      // Round-robin order is owner+1 .. NUM_REQ-1, 0 .. owner. Candidates are
      // visited in reverse order and each hit overwrites the previous one, so
      // the last write is the highest-priority requester.
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_valid[j] && (j <= int'(r_owner)) &&
             !(w_excl && (j == int'(r_owner)))) begin
            w_win_valid = 1'b1;
            w_win_idx   = 2'(j);
         end
      end
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_valid[j] && (j > int'(r_owner))) begin
            w_win_valid = 1'b1;
            w_win_idx   = 2'(j);
         end
      end

      w_win_val   = '0;
      w_owner_val = '0;
      w_owner_req = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (w_win_idx == 2'(j)) w_win_val = req_value[j*DATA_W +: DATA_W];
         if (r_owner == 2'(j)) begin
            w_owner_val = req_value[j*DATA_W +: DATA_W];
            w_owner_req = req_valid[j];
         end
      end

      w_grant   = 1'b0;
      w_update  = 1'b0;
      w_to_keep = 1'b0;
      w_to_idle = 1'b0;
      case (r_state)
         S_IDLE: w_grant = w_win_valid;
         S_HOLD: begin
            if (r_cnt != '0) begin
               w_update = w_owner_req;
            end else if (w_win_valid) begin
               w_grant = 1'b1;
            end else if (w_owner_req) begin
               w_update  = 1'b1;
               w_to_keep = 1'b1;
            end else begin
               w_to_idle = 1'b1;
            end
         end
         S_KEEP: begin
            if (w_win_valid)      w_grant   = 1'b1;
            else if (w_owner_req) w_update  = 1'b1;
            else                  w_to_idle = 1'b1;
         end
         default: w_to_idle = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_owner <= 2'd0;
         r_ack   <= '0;
         r_val   <= '0;
         r_sat   <= 1'b0;
         r_busy  <= 1'b0;
`ifdef DISPLAY_ARB_BLANK_EN
         r_blank <= 1'b0;
`endif
      end else begin
         r_ack <= '0;
`ifdef DISPLAY_ARB_BLANK_EN
         r_blank <= 1'b0;
`endif
         if (w_grant) begin
            r_val   <= f_sat(w_win_val);
            r_sat   <= (w_win_val > MAX_V);
            r_owner <= w_win_idx;
            r_ack   <= NUM_REQ'(1) << w_win_idx;
            r_cnt   <= CNT_LOAD;
            r_state <= S_HOLD;
            r_busy  <= 1'b1;
`ifdef DISPLAY_ARB_BLANK_EN
            // Blank for the latch cycle to hide the swap between sources.
            r_blank <= 1'b1;
`endif
         end else begin
            if (w_update) begin
               r_val <= f_sat(w_owner_val);
               r_sat <= (w_owner_val > MAX_V);
            end
            if ((r_state == S_HOLD) && (r_cnt != '0)) r_cnt <= r_cnt - CNT_W'(1);
            if (w_to_keep) r_state <= S_KEEP;
            if (w_to_idle) begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
`ifdef DISPLAY_ARB_BLANK_EN
               r_val   <= '0;
               r_sat   <= 1'b0;
               r_blank <= 1'b1;
`endif
            end
`ifdef DISPLAY_ARB_BLANK_EN
            if (r_state == S_IDLE) r_blank <= 1'b1;
`endif
         end
      end
   end

   assign req_ack       = r_ack;
   assign to_display_nr = r_val;
   assign owner         = r_owner;
   assign busy          = r_busy;
   assign saturated     = r_sat;
   assign dbg_state     = r_state;
`ifdef DISPLAY_ARB_BLANK_EN
   assign display_blank = r_blank;
`else
   assign display_blank = 1'b0;
`endif

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 4-digit 7-segment display between up to NUM_REQ value sources, e.g. operand entry, ALU result and error code.
- Grants ownership round-robin and enforces a minimum show time per grant.
- Drives to_display_nr of the display driver and reports the current owner.
- Sits between the calculator core and the display driver. The display driver is unchanged.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- DATA_W, 14, width of each value and of to_display_nr.
- MAX_VALUE, 9999, largest displayable value; larger inputs saturate.
- HOLD_CYCLES, 50000000, minimum clocks an owner keeps the display (>=2). Benches set it to 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  level request per source; bit i = source i.
- req_value  in  NUM_REQ*DATA_W  packed values; source i at [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-cycle pulse: source i's value was latched this cycle.
- to_display_nr  out  DATA_W  registered value to the display driver.
- display_blank  out  1  blank request to the display driver.
- owner  out  2  index of the current owner (valid when busy=1).
- busy  out  1  1 in HOLD or KEEP.
- saturated  out  1  1 while the displayed value was clamped.

Behaviour:
- Reset (reset=0, async): state=IDLE, to_display_nr=0, req_ack=0, owner=0, busy=0, saturated=0, display_blank=0, hold counter=0, round-robin pointer=0. Mid-operation reset aborts immediately with no ack.
- States: IDLE, HOLD, KEEP. All outputs are registered.
- Arbitration (combinational, evaluated in IDLE and KEEP, and in HOLD only on its final cycle):
  - Search starts at (last_owner+1) mod NUM_REQ and wraps.
  - The first set req_valid bit wins.
  - In KEEP, the current owner is excluded from the search.
- IDLE:
  - Any req_valid set → on that edge: latch the winner's value, owner=winner, req_ack[winner]=1, counter=HOLD_CYCLES-1, go to HOLD.
  - Latency from req_valid to to_display_nr is 1 clock.
- HOLD:
  - Counter decrements each clock.
  - While req_valid[owner]=1, to_display_nr follows the owner's value each clock (live update). No ack is issued for these updates.
  - If the owner drops req_valid, the last value stays displayed. The grant is not shortened.
  - At counter=0, evaluate in priority order:
    - Another source is requesting → re-grant to the arbitration winner: latch, ack, reload counter, stay in HOLD.
    - Else the owner is still requesting → go to KEEP.
    - Else → go to IDLE.
- KEEP:
  - The owner keeps updating live.
  - Any other source requesting → immediate re-grant as from IDLE.
  - Owner drops req_valid → go to IDLE.
- IDLE retains the last to_display_nr and sets busy=0.
- Saturation: if the latched value > MAX_VALUE, to_display_nr=MAX_VALUE and saturated=1. Otherwise saturated=0. Recomputed on every latch or update.
- Ack rules:
  - At most one req_ack bit is high per cycle.
  - Never two consecutive acks to the same source without an intervening different grant or IDLE.
  - Round-robin pointer is updated on each grant.
- Simultaneous requests: resolved by the round-robin pointer only. There is no fixed priority.
- Requests from a source never acked remain pending. The arbiter does not drop them.

Optional Feature:
- Macro: DISPLAY_ARB_BLANK_EN.
- Defined:
  - In IDLE, display_blank=1 and to_display_nr=0.
  - display_blank=1 for exactly one clock on every owner change: the latch occurs, but the blank pulse is coincident with req_ack, suppressing ghosting.
- Undefined:
  - display_blank is tied to 0.
  - IDLE retains the last value.

Test Plan (HOLD_CYCLES=4, NUM_REQ=3):
- Reset, then req_valid=3'b001 with value0=5423 → one clock later to_display_nr=5423, req_ack=001 for 1 clock, owner=0, busy=1; KEEP after 4 clocks.
- req_valid=3'b011, values 1432/8483, held → grants alternate 0,1,0,1 every 4 clocks; display alternates 1432/8483; one ack per grant.
- Owner 0 in HOLD, value0 changes 1111→2222 → display shows 2222 on the next clock with no ack; owner drops req at count 2 → display holds until expiry, then IDLE with busy=0.
- value2=12000 → to_display_nr=9999, saturated=1; next grant with 42 → saturated=0.
- reset=0 pulsed asynchronously mid-HOLD → all outputs reach reset values without waiting for a clock edge; no ack is lost or duplicated after release.
- With DISPLAY_ARB_BLANK_EN: IDLE → display_blank=1, value 0; owner change 0→1 → display_blank high for exactly 1 clock.
